// File: rtl/tx_cu.sv
// Splits each 16-bit FIR result into two UART bytes (MSB first) and handshakes
// each byte with the transmitter's busy flag. A one-deep pending buffer absorbs results that arrive mid-frame.
module tx_cu #(
   parameter int GAP_CYCLES  = 2,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        FIR_valid,
   input  logic [15:0] FIR_out,
   input  logic        TxD_busy,
   output logic        TxD_start,
   output logic [7:0]  TxD_data,
   output logic        ready,
   output logic        tx_done,
   output logic        tx_ovf,
   output logic        tx_err
);

   typedef enum logic [3:0] {
      IDLE, SEND_MSB, ACK_MSB, WAIT_MSB, GAP, SEND_LSB, ACK_LSB, WAIT_LSB, DONE
   } state_t;

   localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
   localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES - 1);

   state_t      state;
   logic [15:0] hold;
   logic [15:0] pend;
   logic        pend_valid;
   logic        restart;
   logic [7:0]  cnt;

   // restart marks a hold register reloaded by a timeout abort, so IDLE resends at once
   assign ready = (state == IDLE) && !restart && !pend_valid;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         hold       <= 16'h0000;
         pend       <= 16'h0000;
         pend_valid <= 1'b0;
         restart    <= 1'b0;
         cnt        <= 8'h00;
         TxD_start  <= 1'b0;
         TxD_data   <= 8'h00;
         tx_done    <= 1'b0;
         tx_ovf     <= 1'b0;
         tx_err     <= 1'b0;
      end else begin
         TxD_start <= 1'b0;
         tx_done   <= 1'b0;
         tx_err    <= 1'b0;

         // Results arriving while busy go to the pending slot; a full slot drops them.
         // States that consume the slot below override these assignments.
         if (FIR_valid && (state != IDLE || restart)) begin
            if (pend_valid) begin
               tx_ovf <= 1'b1;
            end else begin
               pend       <= FIR_out;
               pend_valid <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (restart) begin
                  restart   <= 1'b0;
                  state     <= SEND_MSB;
                  TxD_start <= 1'b1;
                  TxD_data  <= hold[15:8];
               end else if (FIR_valid) begin
                  hold      <= FIR_out;
                  state     <= SEND_MSB;
                  TxD_start <= 1'b1;
                  TxD_data  <= FIR_out[15:8];
               end
            end
            SEND_MSB: begin
               cnt   <= 8'h00;
               state <= ACK_MSB;
            end
            ACK_MSB, ACK_LSB: begin
               if (TxD_busy) begin
                  state <= (state == ACK_MSB) ? WAIT_MSB : WAIT_LSB;
               end else if (cnt == ACK_LAST) begin
                  tx_err <= 1'b1;
                  state  <= IDLE;
                  if (pend_valid) begin
                     hold       <= pend;
                     pend_valid <= 1'b0;
                     restart    <= 1'b1;
                  end else if (FIR_valid) begin
                     hold       <= FIR_out;
                     pend_valid <= 1'b0;
                     restart    <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            WAIT_MSB: begin
               if (!TxD_busy) begin
                  if (GAP_CYCLES == 0) begin
                     state     <= SEND_LSB;
                     TxD_start <= 1'b1;
                     TxD_data  <= hold[7:0];
                  end else begin
                     cnt   <= 8'h00;
                     state <= GAP;
                  end
               end
            end
            GAP: begin
               if (cnt == GAP_LAST) begin
                  state     <= SEND_LSB;
                  TxD_start <= 1'b1;
                  TxD_data  <= hold[7:0];
               end else begin
                  cnt <= cnt + 8'd1;
               end
            end
            SEND_LSB: begin
               cnt   <= 8'h00;
               state <= ACK_LSB;
            end
            WAIT_LSB: begin
               if (!TxD_busy) begin
                  state   <= DONE;
                  tx_done <= 1'b1;
               end
            end
            DONE: begin
               if (pend_valid) begin
                  hold       <= pend;
                  pend_valid <= 1'b0;
                  state      <= SEND_MSB;
                  TxD_start  <= 1'b1;
                  TxD_data   <= pend[15:8];
               end else if (FIR_valid) begin
                  hold       <= FIR_out;
                  pend_valid <= 1'b0;
                  state      <= SEND_MSB;
                  TxD_start  <= 1'b1;
                  TxD_data   <= FIR_out[15:8];
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_tx_cu.sv
// Directed bench for tx_cu: one default instance and one GAP_CYCLES=0 instance,
// each driven by a small UART model (1-cycle delay, then busy for 10 cycles).
module tb_tx_cu;

   logic        clk = 1'b0;
   logic        rst;
   logic        firValidA, firValidB;
   logic [15:0] firOutA, firOutB;
   logic        startA, startB, readyA, readyB;
   logic        doneA, doneB, ovfA, ovfB, errA, errB;
   logic [7:0]  dataA, dataB;
   logic [1:0]  busy, seen, uartEn, startV;
   int          left [2];
   int          cyc = 0;
   int          stimCyc;
   int          nChecks = 0;
   int          nPass = 0;

   int          startCycA[$], doneCycA[$], errCycA[$];
   logic [7:0]  startDatA[$];
   int          startCycB[$], doneCycB[$];
   logic [7:0]  startDatB[$];

   tx_cu dutA (
      .clk(clk), .rst(rst), .FIR_valid(firValidA), .FIR_out(firOutA),
      .TxD_busy(busy[0]), .TxD_start(startA), .TxD_data(dataA), .ready(readyA),
      .tx_done(doneA), .tx_ovf(ovfA), .tx_err(errA)
   );

   tx_cu #(.GAP_CYCLES(0), .ACK_TIMEOUT(255)) dutB (
      .clk(clk), .rst(rst), .FIR_valid(firValidB), .FIR_out(firOutB),
      .TxD_busy(busy[1]), .TxD_start(startB), .TxD_data(dataB), .ready(readyB),
      .tx_done(doneB), .tx_ovf(ovfB), .tx_err(errB)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   assign startV = {startB, startA};

   // UART model: busy rises one cycle after the start pulse is seen and stays high 10 cycles
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            busy[i] <= 1'b0;
            seen[i] <= 1'b0;
            left[i] <= 0;
         end else begin
            if (seen[i]) begin
               busy[i] <= 1'b1;
               left[i] <= 10;
            end else if (busy[i]) begin
               if (left[i] == 1) busy[i] <= 1'b0;
               left[i] <= left[i] - 1;
            end
            seen[i] <= uartEn[i] && startV[i];
         end
      end
   end

   always @(negedge clk) begin
      if (startA) begin
         startCycA.push_back(cyc);
         startDatA.push_back(dataA);
      end
      if (doneA) doneCycA.push_back(cyc);
      if (errA) errCycA.push_back(cyc);
      if (startB) begin
         startCycB.push_back(cyc);
         startDatB.push_back(dataB);
      end
      if (doneB) doneCycB.push_back(cyc);
   end

   function automatic int sCycA(input int i);
      if (i < startCycA.size()) return startCycA[i];
      return -1;
   endfunction

   function automatic logic [7:0] sDatA(input int i);
      if (i < startDatA.size()) return startDatA[i];
      return 8'hxx;
   endfunction

   function automatic int dCycA(input int i);
      if (i < doneCycA.size()) return doneCycA[i];
      return -1;
   endfunction

   function automatic int eCycA(input int i);
      if (i < errCycA.size()) return errCycA[i];
      return -1;
   endfunction

   function automatic int sCycB(input int i);
      if (i < startCycB.size()) return startCycB[i];
      return -1;
   endfunction

   function automatic logic [7:0] sDatB(input int i);
      if (i < startDatB.size()) return startDatB[i];
      return 8'hxx;
   endfunction

   function automatic int qSize(input int sel);
      case (sel)
         0:       return doneCycA.size();
         1:       return errCycA.size();
         default: return doneCycB.size();
      endcase
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      nChecks++;
      if (actual === expected) nPass++;
      else $display("[TB] FAIL %s: got %0h, required %0h", tag, actual, expected);
   endtask

   task automatic applyStimulus(input int sel, input logic [15:0] v);
      @(posedge clk); #1;
      if (sel == 0) begin
         firValidA = 1'b1;
         firOutA   = v;
      end else begin
         firValidB = 1'b1;
         firOutB   = v;
      end
      stimCyc = cyc;
      @(posedge clk); #1;
      firValidA = 1'b0;
      firValidB = 1'b0;
   endtask

   task automatic doReset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Bounded wait for an event queue to reach n entries; the outcome is itself a check
   task automatic waitEvents(input string tag, input int sel, input int n, input int budget);
      int k = 0;
      while (qSize(sel) < n && k < budget) begin
         @(posedge clk); #1;
         k++;
      end
      checkOutput(tag, qSize(sel), n);
   endtask

   initial begin
      int base, bd, be, baseB, bdB;
      rst = 1'b1;
      firValidA = 1'b0; firValidB = 1'b0;
      firOutA = 16'h0000; firOutB = 16'h0000;
      uartEn = 2'b11;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      checkOutput("rst_ready", readyA, 1);
      checkOutput("rst_start", startA, 0);
      checkOutput("rst_data", dataA, 8'h00);
      checkOutput("rst_done", doneA, 0);
      checkOutput("rst_err", errA, 0);
      checkOutput("rst_ovf", ovfA, 0);
      checkOutput("rst_readyB", readyB, 1);

      // Single frame A5C3: MSB one cycle after strobe, LSB 15 later, done 13 after LSB
      base = startCycA.size(); bd = doneCycA.size();
      applyStimulus(0, 16'hA5C3);
      checkOutput("t1_busy_ready", readyA, 0);
      waitEvents("t1_wait_done", 0, bd + 1, 100);
      checkOutput("t1_nstart", startCycA.size() - base, 2);
      checkOutput("t1_msb_data", sDatA(base), 8'hA5);
      checkOutput("t1_msb_cyc", sCycA(base), stimCyc + 1);
      checkOutput("t1_lsb_data", sDatA(base + 1), 8'hC3);
      checkOutput("t1_gap", sCycA(base + 1) - sCycA(base), 15);
      checkOutput("t1_done_cyc", dCycA(bd) - sCycA(base + 1), 13);
      repeat (2) @(posedge clk); #1;
      checkOutput("t1_ready", readyA, 1);

      // Second result during MSB transmit goes out right after DONE
      base = startCycA.size(); bd = doneCycA.size();
      applyStimulus(0, 16'hA5C3);
      repeat (2) @(posedge clk); #1;
      applyStimulus(0, 16'h1234);
      waitEvents("t2_wait_done", 0, bd + 2, 200);
      checkOutput("t2_nstart", startCycA.size() - base, 4);
      checkOutput("t2_b2_data", sDatA(base + 2), 8'h12);
      checkOutput("t2_b3_data", sDatA(base + 3), 8'h34);
      checkOutput("t2_back2back", sCycA(base + 2), dCycA(bd) + 1);
      checkOutput("t2_gap", sCycA(base + 3) - sCycA(base + 2), 15);
      checkOutput("t2_ovf", ovfA, 0);

      // Three strobes during one frame: first kept, next two dropped, sticky overflow
      base = startCycA.size(); bd = doneCycA.size();
      applyStimulus(0, 16'hA5C3);
      repeat (2) @(posedge clk); #1;
      applyStimulus(0, 16'h1111);
      applyStimulus(0, 16'h2222);
      applyStimulus(0, 16'h3333);
      checkOutput("t3_ovf_set", ovfA, 1);
      waitEvents("t3_wait_done", 0, bd + 2, 200);
      repeat (60) @(posedge clk); #1;
      checkOutput("t3_nstart", startCycA.size() - base, 4);
      checkOutput("t3_b2_data", sDatA(base + 2), 8'h11);
      checkOutput("t3_b3_data", sDatA(base + 3), 8'h11);
      checkOutput("t3_ovf_sticky", ovfA, 1);
      checkOutput("t3_ready", readyA, 1);

      // ACK timeout: SEND at t, 255 ACK cycles, error pulse in cycle t+256
      doReset();
      checkOutput("t4_ovf_cleared", ovfA, 0);
      uartEn[0] = 1'b0;
      base = startCycA.size(); be = errCycA.size();
      applyStimulus(0, 16'hA5C3);
      waitEvents("t4_wait_err", 1, be + 1, 300);
      checkOutput("t4_err_cyc", eCycA(be) - sCycA(base), 256);
      repeat (5) @(posedge clk); #1;
      checkOutput("t4_nstart", startCycA.size() - base, 1);
      checkOutput("t4_ready", readyA, 1);
      checkOutput("t4_start_low", startA, 0);

      // Timeout with a pending result: it is resent the cycle after the error
      base = startCycA.size(); be = errCycA.size();
      applyStimulus(0, 16'hA5C3);
      repeat (3) @(posedge clk); #1;
      applyStimulus(0, 16'h1234);
      waitEvents("t5_wait_err", 1, be + 1, 300);
      repeat (3) @(posedge clk); #1;
      checkOutput("t5_resend_data", sDatA(base + 1), 8'h12);
      checkOutput("t5_resend_cyc", sCycA(base + 1), eCycA(be) + 1);
      waitEvents("t5_wait_err2", 1, be + 2, 300);
      repeat (3) @(posedge clk); #1;
      checkOutput("t5_nstart", startCycA.size() - base, 2);
      checkOutput("t5_ready", readyA, 1);
      uartEn[0] = 1'b1;

      // Reset during WAIT_LSB (stimulus cycle + 20) aborts silently
      doReset();
      base = startCycA.size(); bd = doneCycA.size();
      applyStimulus(0, 16'hA5C3);
      repeat (19) @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("t6_start", startA, 0);
      checkOutput("t6_data", dataA, 8'h00);
      checkOutput("t6_done", doneA, 0);
      checkOutput("t6_err", errA, 0);
      checkOutput("t6_ready", readyA, 1);
      repeat (30) @(posedge clk); #1;
      checkOutput("t6_no_done", doneCycA.size() - bd, 0);
      checkOutput("t6_nstart", startCycA.size() - base, 2);
      base = startCycA.size();
      applyStimulus(0, 16'h1234);
      waitEvents("t6_wait_done", 0, bd + 1, 100);
      checkOutput("t6_msb_data", sDatA(base), 8'h12);
      checkOutput("t6_lsb_data", sDatA(base + 1), 8'h34);
      checkOutput("t6_gap", sCycA(base + 1) - sCycA(base), 15);

      // Zero-gap build: LSB starts the cycle after busy falls
      baseB = startCycB.size(); bdB = doneCycB.size();
      applyStimulus(1, 16'hFF00);
      waitEvents("t7_wait_done", 2, bdB + 1, 100);
      checkOutput("t7_msb_data", sDatB(baseB), 8'hFF);
      checkOutput("t7_lsb_data", sDatB(baseB + 1), 8'h00);
      checkOutput("t7_gap", sCycB(baseB + 1) - sCycB(baseB), 13);
      checkOutput("t7_msb_cyc", sCycB(baseB), stimCyc + 1);
      checkOutput("t7_ovfB", ovfB, 0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

endmodule
